tdc_therm_decoder: RTL and testbench
====================================

// Module: tdc_therm_decoder
// PURPOSE
// - Downstream of the TDC delay line. Samples the N_DELAY-bit thermometer result on clk.
// - Reduces each sample to a binary ones-count (popcount) and raises status flags.
// - Presents the code on a valid/ready handshake, replacing the 8-bit slice mux readout.
// PARAMETERS
// - N_DELAY   256  thermometer width; power of 2, 8..256
// - CODE_W    $clog2(N_DELAY)+1  code width; represents 0..N_DELAY inclusive
// - AVG_LOG2  2    log2 of averaging window (only with TDC_DEC_AVG_EN)
// PORTS
// - clk         in   1        clock; also the TDC stop edge
// - rst_n       in   1        synchronous reset, active-low
// - i_result    in   N_DELAY  thermometer from TDC; bit i=1 means start passed stage i
// - i_meas_en   in   1        sample i_result in this cycle
// - i_ready     in   1        consumer accepts o_code when o_valid=1
// - o_code      out  CODE_W   ones-count of the sample (or window mean)
// - o_valid     out  1        o_code and flags valid; held until accepted
// - o_overflow  out  1        sample was all ones (edge beyond the line)
// - o_empty     out  1        sample was all zeros (stop before start)
// - o_bubble    out  1        non-monotonic: some 0 below a higher 1
// - o_drop_cnt  out  8        saturating count of results lost to backpressure
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): all pipeline regs, o_code, flags, o_valid, o_drop_cnt = 0.
// - S1, cycle t with i_meas_en=1: i_result captured into s1_q; s1_v=1 at t+1.
// - S2, t+1: popcount(s1_q), overflow/empty/bubble computed and registered; result ready at t+2.
// - Output reg: if empty, or (o_valid & i_ready), load S2 result; o_valid=1 from t+2.
//   Latency is 2 cycles; back-to-back throughput is 1 per cycle while i_ready=1.
// - Handshake: transfer when o_valid & i_ready at a posedge. o_code and flags stay stable
//   while o_valid=1 & i_ready=0. o_valid drops after transfer unless a new result loads.
// - Backpressure: S2 result arriving while the output is full and i_ready=0 is discarded;
//   the held output is untouched; o_drop_cnt++ saturates at 255. No stall of S1/S2.
// - Same-cycle transfer + new S2 result: the new result loads and o_valid stays 1; no drop.
// - Bubble: bubble = OR_i(~r[i] & r[i+1]). The code is still the popcount; no correction.
// - overflow and empty are mutually exclusive. all-ones gives code=N_DELAY; all-zeros gives 0.
// - Reset mid-operation: in-flight samples lost; o_drop_cnt cleared.
// - i_meas_en=0: nothing enters S1. The output holds its content.
// CONFIGURATION
// - TDC_DEC_AVG_EN undefined: every popcount result goes to the output as above.
// - TDC_DEC_AVG_EN defined: a window of 2^AVG_LOG2 S2 results is summed into a
//   CODE_W+AVG_LOG2-bit accumulator.
//   - On the last result of the window, o_code = acc>>AVG_LOG2 (truncating).
//   - Flags are OR-ed over the window.
//   - Accumulator and window counter restart at 0.
//   - Only the window result is offered on the handshake.
//   - Latency is 2 cycles after the last sample of the window.
//   - Drops are counted per window result. Reset clears the partial window.
// TESTING
// - All tests use N_DELAY=16, CODE_W=5.
// - T1: reset then meas_en with r=16'h00FF, ready=1 -> o_valid at t+2, code=8, all flags 0.
// - T2: r=16'hFFFF, then r=16'h0000 -> code=16 with overflow=1; then code=0 with empty=1.
// - T3: r=16'h00F7 -> code=7, bubble=1, overflow=0.
// - T4: ready=0, 4 consecutive samples -> first held stable, drop_cnt=3;
//   then ready=1 -> one transfer, valid drops.
// - T5: drive rst_n=0 for 1 cycle while o_valid=1 and drop_cnt=3 -> next cycle valid=0, drop_cnt=0.
// - T6 (TDC_DEC_AVG_EN, AVG_LOG2=2): codes 4,5,6,8 -> one result, code=5; no output before the 4th.

Source files
------------

// File: rtl/tdc_therm_decoder.sv
// TDC thermometer decoder: popcount + status flags behind a valid/ready output register.
// Optional build macro TDC_DEC_AVG_EN replaces per-sample output with a 2^AVG_LOG2 window mean.
module tdc_therm_decoder #(
  parameter int N_DELAY  = 256,
  parameter int CODE_W   = $clog2(N_DELAY) + 1,
  parameter int AVG_LOG2 = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_DELAY-1:0] i_result,
  input  logic               i_meas_en,
  input  logic               i_ready,
  output logic [CODE_W-1:0]  o_code,
  output logic               o_valid,
  output logic               o_overflow,
  output logic               o_empty,
  output logic               o_bubble,
  output logic [7:0]         o_drop_cnt
);

  if (N_DELAY < 8 || N_DELAY > 256 || (N_DELAY & (N_DELAY - 1)) != 0 || AVG_LOG2 < 1) begin : g_bad_cfg
    $error("tdc_therm_decoder: unsupported N_DELAY/AVG_LOG2 configuration");
  end

  logic [N_DELAY-1:0] s1_q;
  logic               s1_v;
  logic [CODE_W-1:0]  pop;
  logic               cur_ovf;
  logic               cur_emp;
  logic               cur_bub;

  logic               res_v;
  logic [CODE_W-1:0]  res_code;
  logic               res_ovf;
  logic               res_emp;
  logic               res_bub;

  logic               load;
  logic               drop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s1_v <= 1'b0;
    end else begin
      s1_v <= i_meas_en;
      if (i_meas_en) s1_q <= i_result;
    end
  end

  // Bubble marks any stage that reads 0 while the stage above it reads 1.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N_DELAY; i++) begin
      pop = pop + CODE_W'(s1_q[i]);
    end
    cur_ovf = &s1_q;
    cur_emp = ~|s1_q;
    cur_bub = |(~s1_q[N_DELAY-2:0] & s1_q[N_DELAY-1:1]);
  end

`ifdef TDC_DEC_AVG_EN
  localparam int ACC_W = CODE_W + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] CNT_ONE = 1;

  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_sum;
  logic [AVG_LOG2-1:0] win_cnt;
  logic                win_last;
  logic                win_ovf;
  logic                win_emp;
  logic                win_bub;

  always_comb begin
    acc_sum  = acc + ACC_W'(pop);
    win_last = &win_cnt;
    res_v    = s1_v & win_last;
    res_code = acc_sum[AVG_LOG2 +: CODE_W];
    res_ovf  = win_ovf | cur_ovf;
    res_emp  = win_emp | cur_emp;
    res_bub  = win_bub | cur_bub;
  end

  // The window restarts on its last sample whether or not the result is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      win_cnt <= '0;
      win_ovf <= 1'b0;
      win_emp <= 1'b0;
      win_bub <= 1'b0;
    end else if (s1_v) begin
      if (win_last) begin
        acc     <= '0;
        win_cnt <= '0;
        win_ovf <= 1'b0;
        win_emp <= 1'b0;
        win_bub <= 1'b0;
      end else begin
        acc     <= acc_sum;
        win_cnt <= win_cnt + CNT_ONE;
        win_ovf <= res_ovf;
        win_emp <= res_emp;
        win_bub <= res_bub;
      end
    end
  end
`else
  always_comb begin
    res_v    = s1_v;
    res_code = pop;
    res_ovf  = cur_ovf;
    res_emp  = cur_emp;
    res_bub  = cur_bub;
  end
`endif

  assign load = res_v & (~o_valid | i_ready);
  assign drop = res_v & o_valid & ~i_ready;

  // Output register doubles as the second pipeline stage; a full, stalled output discards new results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid    <= 1'b0;
      o_code     <= '0;
      o_overflow <= 1'b0;
      o_empty    <= 1'b0;
      o_bubble   <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      if (load) begin
        o_valid    <= 1'b1;
        o_code     <= res_code;
        o_overflow <= res_ovf;
        o_empty    <= res_emp;
        o_bubble   <= res_bub;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      if (drop && o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// Scoreboard bench for tdc_therm_decoder at N_DELAY=16; build with TDC_DEC_AVG_EN for the window test.
module tb_tdc_therm_decoder;

  typedef struct packed {
    logic [4:0] code;
    logic       ovf;
    logic       emp;
    logic       bub;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_result;
  logic        i_meas_en;
  logic        i_ready;
  logic [4:0]  o_code;
  logic        o_valid;
  logic        o_overflow;
  logic        o_empty;
  logic        o_bubble;
  logic [7:0]  o_drop_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  tdc_therm_decoder #(.N_DELAY(16), .CODE_W(5), .AVG_LOG2(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_result   (i_result),
    .i_meas_en  (i_meas_en),
    .i_ready    (i_ready),
    .o_code     (o_code),
    .o_valid    (o_valid),
    .o_overflow (o_overflow),
    .o_empty    (o_empty),
    .o_bubble   (o_bubble),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Every accepted transfer is checked against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && o_valid === 1'b1 && i_ready === 1'b1) begin
      exp_t e;
      exp_t got;
      checks++;
      got = '{o_code, o_overflow, o_empty, o_bubble};
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL scoreboard_unexpected: got code=%0d ovf=%b emp=%b bub=%b, required no transfer",
                 o_code, o_overflow, o_empty, o_bubble);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("[TB] FAIL scoreboard: got code=%0d ovf=%b emp=%b bub=%b, required code=%0d ovf=%b emp=%b bub=%b",
                   o_code, o_overflow, o_empty, o_bubble, e.code, e.ovf, e.emp, e.bub);
        end
      end
    end
  end

  function automatic exp_t mk(input int code, input bit ovf, input bit emp, input bit bub);
    mk = '{5'(code), ovf, emp, bub};
  endfunction

  task automatic apply_stimulus(input logic [15:0] r, input bit keep, input exp_t e);
    @(posedge clk);
    #1;
    i_meas_en = 1'b1;
    i_result  = r;
    if (keep) exp_q.push_back(e);
  endtask

  task automatic stop_meas();
    @(posedge clk);
    #1;
    i_meas_en = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    i_meas_en = 1'b0;
    i_ready   = 1'b0;
    i_result  = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_valid, o_code, o_overflow, o_empty, o_bubble} !== 9'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got valid=%b code=%0d ovf=%b emp=%b bub=%b, required all 0",
               o_valid, o_code, o_overflow, o_empty, o_bubble);
    end
    checks++;
    if (o_drop_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_drop_cnt: got %0d, required 0", o_drop_cnt);
    end
  endtask

`ifdef TDC_DEC_AVG_EN
  task automatic test_average();
    logic [15:0] win1 [4];
    logic [15:0] win2 [4];
    win1 = '{16'h000F, 16'h001F, 16'h003F, 16'h00FF};
    win2 = '{16'h0000, 16'hFFFF, 16'h00FF, 16'h00FF};
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(win1[i], i == 3, mk(5, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL avg_early_valid: got valid=%b after sample %0d, required 0", o_valid, i);
      end
    end
    stop_meas();
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL avg_latency_early: got valid=%b one cycle after last sample, required 0", o_valid);
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL avg_latency: got valid=%b two cycles after last sample, required 1", o_valid);
    end
    // Mean of 0,16,8,8 is 8 with both ovf and emp seen inside the window.
    for (int i = 0; i < 4; i++) apply_stimulus(win2[i], i == 3, mk(8, 1'b1, 1'b1, 1'b0));
    stop_meas();
    repeat (4) @(negedge clk);
  endtask
`else
  task automatic test_basic();
    i_ready = 1'b1;
    apply_stimulus(16'h00FF, 1'b1, mk(8, 1'b0, 1'b0, 1'b0));
    stop_meas();
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_latency_early: got valid=%b at t+1, required 0", o_valid);
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_latency: got valid=%b at t+2, required 1", o_valid);
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_valid_drop: got valid=%b after transfer, required 0", o_valid);
    end
  endtask

  task automatic test_flags();
    i_ready = 1'b1;
    apply_stimulus(16'hFFFF, 1'b1, mk(16, 1'b1, 1'b0, 1'b0));
    apply_stimulus(16'h0000, 1'b1, mk(0,  1'b0, 1'b1, 1'b0));
    apply_stimulus(16'h00F7, 1'b1, mk(7,  1'b0, 1'b0, 1'b1));
    apply_stimulus(16'h8000, 1'b1, mk(1,  1'b0, 1'b0, 1'b1));
    apply_stimulus(16'h0001, 1'b1, mk(1,  1'b0, 1'b0, 1'b0));
    apply_stimulus(16'h7FFF, 1'b1, mk(15, 1'b0, 1'b0, 1'b0));
    apply_stimulus(16'hFFFE, 1'b1, mk(15, 1'b0, 1'b0, 1'b1));
    stop_meas();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [16:0] t;
    int          k;
    i_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(0, 16);
      t = (17'd1 << k) - 17'd1;
      apply_stimulus(t[15:0], 1'b1, mk(k, k == 16, k == 0, 1'b0));
    end
    stop_meas();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    apply_stimulus(16'h0007, 1'b1, mk(3, 1'b0, 1'b0, 1'b0));
    apply_stimulus(16'h001F, 1'b0, mk(0, 1'b0, 1'b0, 1'b0));
    apply_stimulus(16'h00FF, 1'b0, mk(0, 1'b0, 1'b0, 1'b0));
    apply_stimulus(16'h0FFF, 1'b0, mk(0, 1'b0, 1'b0, 1'b0));
    stop_meas();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b1 || o_code !== 5'd3) begin
        errors++;
        $display("[TB] FAIL bp_hold: got valid=%b code=%0d at cycle %0d, required valid=1 code=3", o_valid, o_code, i);
      end
    end
    checks++;
    if (o_drop_cnt !== 8'd3) begin
      errors++;
      $display("[TB] FAIL bp_drop_cnt: got %0d, required 3", o_drop_cnt);
    end
    @(posedge clk);
    #1 i_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release: got valid=%b after single transfer, required 0", o_valid);
    end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0;
    apply_stimulus(16'h003F, 1'b0, mk(0, 1'b0, 1'b0, 1'b0));
    stop_meas();
    repeat (3) @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_drop_cnt !== 8'd3) begin
      errors++;
      $display("[TB] FAIL reset_mid_setup: got valid=%b drop=%0d, required valid=1 drop=3", o_valid, o_drop_cnt);
    end
    pulse_reset();
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_drop_cnt !== 8'd0 || o_code !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got valid=%b drop=%0d code=%0d, required 0/0/0", o_valid, o_drop_cnt, o_code);
    end
  endtask

  task automatic test_drop_saturation();
    i_ready = 1'b0;
    for (int i = 0; i < 300; i++) apply_stimulus(16'h0003, 1'b0, mk(0, 1'b0, 1'b0, 1'b0));
    stop_meas();
    repeat (3) @(negedge clk);
    checks++;
    if (o_drop_cnt !== 8'd255) begin
      errors++;
      $display("[TB] FAIL drop_saturation: got %0d, required 255", o_drop_cnt);
    end
    checks++;
    if (o_valid !== 1'b1 || o_code !== 5'd2) begin
      errors++;
      $display("[TB] FAIL drop_hold: got valid=%b code=%0d, required valid=1 code=2", o_valid, o_code);
    end
    pulse_reset();
  endtask
`endif

  initial begin
    test_reset();
`ifdef TDC_DEC_AVG_EN
    test_average();
`else
    test_basic();
    test_flags();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_drop_saturation();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d results never delivered, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
